packet_injector: RTL and testbench

- Local-node transmitter for a router's local port. It drives the flit stream that the router's local converter, FIFO and address unit receive.
- Accepts a packet request (destination plus payload length) and a payload flit stream from the node core.
- Emits one header flit followed by the payload flits, honouring the router input buffer's full backpressure.
- Maintains sent-packet and sent-flit statistics counters.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/packet_injector.sv | 100 ++++++++++
 tb/tb_packet_injector.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared types for the NoC local-port blocks: flit and address types,
// the injector state enum and the source-address helper.
package noc_pkg;

  localparam int FLIT_W = 16;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [7:0]        addr_t;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY
  } st_t;

  function automatic addr_t make_src(input logic [3:0] x, input logic [3:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/packet_injector.sv
// Local-node packet injector: sends one header flit, then the payload flits,
// under router-buffer backpressure, and keeps packet and flit statistics.
module packet_injector
  import noc_pkg::*;
#(
  parameter int NODE_X = 0,
  parameter int NODE_Y = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [7:0]  req_dest,
  input  logic [7:0]  req_len,
  output logic        req_ready,
  input  logic        pay_valid,
  input  logic [15:0] pay_data,
  output logic        pay_ready,
  input  logic        buffer_full_in,
  output logic        sending_data,
  output logic [15:0] data_out,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [15:0] flit_count
);

  localparam addr_t SRC_ADDR = make_src(4'(NODE_X), 4'(NODE_Y));

  st_t        state, state_nxt;
  addr_t      dest_q;
  logic [7:0] len_q;
  logic [7:0] remaining;
  logic       pkt_done;
  logic       body_send;

  assign busy      = (state != IDLE);
  assign body_send = pay_valid && !buffer_full_in;

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    pay_ready    = 1'b0;
    sending_data = 1'b0;
    data_out     = '0;
    pkt_done     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = HEAD;
      end
      HEAD: begin
        data_out     = {SRC_ADDR, dest_q};
        sending_data = !buffer_full_in;
        if (!buffer_full_in) begin
          if (len_q == 8'd0) begin
            pkt_done  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = BODY;
          end
        end
      end
      BODY: begin
        data_out     = pay_data;
        pay_ready    = !buffer_full_in;
        sending_data = body_send;
        // completion only on a real send of the final flit
        if (body_send && remaining == 8'd1) begin
          pkt_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dest_q     <= '0;
      len_q      <= '0;
      remaining  <= '0;
      pkt_count  <= '0;
      flit_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        dest_q <= req_dest;
        len_q  <= req_len;
      end
      if (state == HEAD && sending_data && len_q != 8'd0) begin
        remaining <= len_q;
      end else if (state == BODY && sending_data) begin
        remaining <= remaining - 8'd1;
      end
      if (sending_data) flit_count <= flit_count + 16'd1;
      if (pkt_done)     pkt_count  <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_packet_injector.sv
// Self-checking bench for packet_injector: a flit-queue reference model
// checks every pushed flit, plus directed and randomized packet scenarios.
module tb_packet_injector;

  localparam int          NX  = 2;
  localparam int          NY  = 1;
  localparam logic [7:0]  SRC = 8'h21;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_dest = '0;
  logic [7:0]  req_len = '0;
  logic        req_ready;
  logic        pay_valid = 1'b0;
  logic [15:0] pay_data = '0;
  logic        pay_ready;
  logic        buffer_full_in = 1'b0;
  logic        sending_data;
  logic [15:0] data_out;
  logic        busy;
  logic [15:0] pkt_count;
  logic [15:0] flit_count;

  packet_injector #(.NODE_X(NX), .NODE_Y(NY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_dest(req_dest), .req_len(req_len), .req_ready(req_ready),
    .pay_valid(pay_valid), .pay_data(pay_data), .pay_ready(pay_ready),
    .buffer_full_in(buffer_full_in), .sending_data(sending_data), .data_out(data_out),
    .busy(busy), .pkt_count(pkt_count), .flit_count(flit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] flit;
    bit          last;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] exp_pkt = '0;
  logic [15:0] exp_flit = '0;
  logic [15:0] pl [0:255];
  int          checks = 0;
  int          failures = 0;

  // reference model: expected flit stream of every requested packet
  task automatic push_pkt(input logic [7:0] dest, input int len, input int first);
    exp_t e;
    e.flit = {SRC, dest};
    e.last = (len == 0);
    expq.push_back(e);
    for (int i = 0; i < len; i++) begin
      e.flit = pl[first + i];
      e.last = (i == len - 1);
      expq.push_back(e);
    end
  endtask

  // called #1 after a negedge: checks this cycle's push, then advances
  task automatic finish_cycle();
    exp_t e;
    if (!reset && sending_data === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_send data_out=%h", data_out);
      end else begin
        e = expq.pop_front();
        if (data_out !== e.flit) begin
          failures++;
          $display("FAIL flit_order got=%h exp=%h", data_out, e.flit);
        end
        exp_flit = exp_flit + 16'd1;
        if (e.last) exp_pkt = exp_pkt + 16'd1;
      end
    end
    if (!reset && buffer_full_in === 1'b1) begin
      checks++;
      if (sending_data !== 1'b0 || pay_ready !== 1'b0) begin
        failures++;
        $display("FAIL full_blocks sending=%b pay_ready=%b exp=0/0", sending_data, pay_ready);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || pkt_count !== exp_pkt ||
        flit_count !== exp_flit || expq.size() != 0) begin
      failures++;
      $display("FAIL %s busy=%b req_ready=%b pkt=%h/%h flit=%h/%h left=%0d",
               name, busy, req_ready, pkt_count, exp_pkt, flit_count, exp_flit, expq.size());
    end
  endtask

  task automatic run_pkt(input logic [7:0] dest, input int len, input int bp, input int gap);
    int  idx, cyc;
    bit  hdr;
    push_pkt(dest, len, 0);
    req_valid = 1'b1; req_dest = dest; req_len = 8'(len);
    #1;
    finish_cycle();
    req_valid = 1'b0;
    idx = 0; hdr = 0; cyc = 0;
    while (!(hdr && idx == len) && cyc < 5000) begin
      buffer_full_in = ($urandom_range(0, 99) < bp);
      pay_valid      = ($urandom_range(0, 99) >= gap);
      pay_data       = pl[idx < 256 ? idx : 0];
      #1;
      if (sending_data === 1'b1) begin
        if (!hdr) hdr = 1;
        else idx++;
      end
      finish_cycle();
      cyc++;
    end
    buffer_full_in = 1'b0;
    pay_valid = 1'b0;
    if (cyc >= 5000) begin
      failures++;
      $display("FAIL run_pkt_timeout sent=%0d exp=%0d", idx, len);
    end
    #1;
    check_idle("run_pkt_end");
    finish_cycle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || sending_data !== 1'b0 || pay_ready !== 1'b0 || busy !== 1'b0 ||
        data_out !== 16'h0 || pkt_count !== 16'h0 || flit_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_state rr=%b snd=%b pr=%b busy=%b d=%h pkt=%h flit=%h exp=1,0,0,0,0,0,0",
               req_ready, sending_data, pay_ready, busy, data_out, pkt_count, flit_count);
    end
    reset = 1'b0;
    finish_cycle();
  endtask

  task automatic test_basic();
    pl[0] = 16'hAAAA; pl[1] = 16'h5555;
    push_pkt(8'h30, 2, 0);
    req_valid = 1'b1; req_dest = 8'h30; req_len = 8'd2;
    #1;
    finish_cycle();
    req_valid = 1'b0; pay_valid = 1'b1; pay_data = 16'hAAAA;
    #1;
    checks++;
    if (data_out !== 16'h2130 || sending_data !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_header d=%h snd=%b rr=%b busy=%b exp=2130,1,0,1",
               data_out, sending_data, req_ready, busy);
    end
    finish_cycle();
    #1;
    checks++;
    if (data_out !== 16'hAAAA || sending_data !== 1'b1 || pay_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_pay0 d=%h snd=%b pr=%b exp=AAAA,1,1", data_out, sending_data, pay_ready);
    end
    finish_cycle();
    pay_data = 16'h5555;
    #1;
    checks++;
    if (data_out !== 16'h5555 || sending_data !== 1'b1) begin
      failures++;
      $display("FAIL basic_pay1 d=%h snd=%b exp=5555,1", data_out, sending_data);
    end
    finish_cycle();
    pay_valid = 1'b0;
    #1;
    checks++;
    if (pkt_count !== 16'd1 || flit_count !== 16'd3) begin
      failures++;
      $display("FAIL basic_counts pkt=%0d flit=%0d exp=1,3", pkt_count, flit_count);
    end
    check_idle("basic_idle");
    finish_cycle();
  endtask

  task automatic test_header_only();
    push_pkt(8'h01, 0, 0);
    req_valid = 1'b1; req_dest = 8'h01; req_len = 8'd0;
    #1;
    finish_cycle();
    req_valid = 1'b0;
    #1;
    checks++;
    if (data_out !== 16'h2101 || sending_data !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL hdr_only d=%h snd=%b busy=%b exp=2101,1,1", data_out, sending_data, busy);
    end
    finish_cycle();
    #1;
    check_idle("hdr_only_idle");
    finish_cycle();
  endtask

  task automatic test_backpressure();
    logic [15:0] f0;
    f0 = exp_flit;
    pl[0] = 16'hA001; pl[1] = 16'hB002;
    push_pkt(8'h7C, 2, 0);
    req_valid = 1'b1; req_dest = 8'h7C; req_len = 8'd2;
    #1;
    finish_cycle();
    req_valid = 1'b0; pay_valid = 1'b1; pay_data = pl[0];
    for (int i = 0; i < 4; i++) begin
      buffer_full_in = 1'b1;
      #1;
      checks++;
      if (sending_data !== 1'b0 || data_out !== 16'h217C || pay_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_head c%0d snd=%b d=%h pr=%b exp=0,217C,0", i, sending_data, data_out, pay_ready);
      end
      finish_cycle();
    end
    buffer_full_in = 1'b0;
    #1;
    finish_cycle();
    #1;
    finish_cycle();
    pay_data = pl[1];
    for (int i = 0; i < 2; i++) begin
      buffer_full_in = 1'b1;
      #1;
      checks++;
      if (sending_data !== 1'b0 || data_out !== 16'hB002 || pay_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_body c%0d snd=%b d=%h pr=%b busy=%b exp=0,B002,0,1",
                 i, sending_data, data_out, pay_ready, busy);
      end
      finish_cycle();
    end
    buffer_full_in = 1'b0;
    #1;
    finish_cycle();
    pay_valid = 1'b0;
    #1;
    checks++;
    if (flit_count !== f0 + 16'd3) begin
      failures++;
      $display("FAIL bp_flits flit=%h exp=%h", flit_count, f0 + 16'd3);
    end
    check_idle("bp_idle");
    finish_cycle();
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 4; i++) pl[i] = 16'($urandom);
    push_pkt(8'h5A, 4, 0);
    req_valid = 1'b1; req_dest = 8'h5A; req_len = 8'd4;
    #1;
    finish_cycle();
    req_valid = 1'b0; pay_valid = 1'b1; pay_data = pl[0];
    #1;
    finish_cycle();
    for (int i = 0; i < 2; i++) begin
      pay_data = pl[i];
      #1;
      finish_cycle();
    end
    pay_valid = 1'b0;
    pay_data = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (sending_data !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || pay_ready !== 1'b1) begin
        failures++;
        $display("FAIL starve c%0d snd=%b busy=%b rr=%b pr=%b exp=0,1,0,1",
                 i, sending_data, busy, req_ready, pay_ready);
      end
      finish_cycle();
    end
    pay_valid = 1'b1;
    pay_data = pl[2];
    #1;
    finish_cycle();
    pay_data = pl[3];
    #1;
    checks++;
    if (busy !== 1'b1 || sending_data !== 1'b1) begin
      failures++;
      $display("FAIL starve_resume busy=%b snd=%b exp=1,1", busy, sending_data);
    end
    finish_cycle();
    pay_valid = 1'b0;
    #1;
    check_idle("starve_idle");
    finish_cycle();
  endtask

  task automatic test_reset_mid_body();
    for (int i = 0; i < 3; i++) pl[i] = 16'h1000 + 16'(i);
    push_pkt(8'h33, 3, 0);
    req_valid = 1'b1; req_dest = 8'h33; req_len = 8'd3;
    #1;
    finish_cycle();
    req_valid = 1'b0; pay_valid = 1'b1; pay_data = pl[0];
    #1;
    finish_cycle();
    #1;
    finish_cycle();
    pay_data = pl[1];
    reset = 1'b1;
    expq.delete();
    exp_pkt = '0;
    exp_flit = '0;
    #1;
    checks++;
    if (sending_data !== 1'b0 || req_ready !== 1'b1 || pkt_count !== 16'h0 ||
        flit_count !== 16'h0 || busy !== 1'b0 || data_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid snd=%b rr=%b pkt=%h flit=%h busy=%b d=%h exp=0,1,0,0,0,0",
               sending_data, req_ready, pkt_count, flit_count, busy, data_out);
    end
    finish_cycle();
    reset = 1'b0;
    pay_valid = 1'b0;
    #1;
    finish_cycle();
    pl[0] = 16'hC0DE;
    run_pkt(8'h44, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int p = 0; p < 20; p++) begin
      int len;
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) pl[i] = 16'($urandom);
      run_pkt(8'($urandom), len, 30, 25);
    end
  endtask

  task automatic test_back_to_back_wrap();
    bit          sent_log [0:399];
    logic [15:0] pk_log [0:399];
    int          idx, nsend, accepts, cyc, p2, p3, run;
    force dut.pkt_count = 16'hFFFF;
    #1;
    release dut.pkt_count;
    exp_pkt = 16'hFFFF;
    checks++;
    if (pkt_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL preload pkt=%h exp=FFFF", pkt_count);
    end
    finish_cycle();
    for (int i = 0; i < 256; i++) pl[i] = 16'($urandom);
    push_pkt(8'h12, 1, 0);
    push_pkt(8'hE7, 255, 1);
    req_valid = 1'b1; req_dest = 8'h12; req_len = 8'd1;
    idx = 0; nsend = 0; accepts = 0; cyc = 0;
    while (!(accepts == 2 && nsend == 258) && cyc < 400) begin
      if (accepts == 1) begin req_dest = 8'hE7; req_len = 8'd255; end
      if (accepts == 2) req_valid = 1'b0;
      pay_valid = 1'b1;
      pay_data = pl[idx < 256 ? idx : 0];
      #1;
      sent_log[cyc] = (sending_data === 1'b1);
      pk_log[cyc] = pkt_count;
      if (req_ready === 1'b1 && req_valid) accepts++;
      if (pay_ready === 1'b1 && pay_valid) idx++;
      if (sending_data === 1'b1) nsend++;
      finish_cycle();
      cyc++;
    end
    req_valid = 1'b0;
    pay_valid = 1'b0;
    if (cyc >= 400) begin
      failures++;
      $display("FAIL b2b_timeout sends=%0d exp=258", nsend);
    end
    p2 = -1; p3 = -1; run = 0; nsend = 0;
    for (int c = 0; c < cyc; c++) begin
      if (sent_log[c]) begin
        nsend++;
        if (nsend == 2) p2 = c;
        if (nsend == 3) p3 = c;
        if (nsend >= 3) run++;
      end
    end
    checks++;
    if (!sent_log[1] || sent_log[0]) begin
      failures++;
      $display("FAIL b2b_latency first_send_cycle0=%b cycle1=%b exp=0,1", sent_log[0], sent_log[1]);
    end
    checks++;
    if (p2 < 0 || p3 - p2 != 2) begin
      failures++;
      $display("FAIL b2b_gap gap=%0d exp=2", p3 - p2);
    end
    checks++;
    if (p2 < 0 || sent_log[p2 + 1] || pk_log[p2 + 1] !== 16'h0) begin
      failures++;
      $display("FAIL wrap_zero pkt=%h exp=0000", (p2 < 0) ? 16'hXXXX : pk_log[p2 + 1]);
    end
    checks++;
    if (run != 256 || p3 < 0 || !sent_log[p3 + 255]) begin
      failures++;
      $display("FAIL len255_sends got=%0d exp=256", run);
    end
    #1;
    checks++;
    if (pkt_count !== 16'd1) begin
      failures++;
      $display("FAIL wrap_one pkt=%h exp=0001", pkt_count);
    end
    check_idle("b2b_idle");
    finish_cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_header_only();
    test_backpressure();
    test_starvation();
    test_reset_mid_body();
    test_random();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
